// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1/8E1/8O1 serial receive stage with a
// one-entry holding register, valid/read handshake and per-frame error flags.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle; waiting for rx_s low on a bclk; parity config tracked
// START  | qualifying start bit; re-checked at mid-bit to reject glitches
// DATA   | sampling DATA_BITS data bits, LSB first, one per full bit period
// PARITY | sampling the parity bit (only when parity was enabled at start)
// STOP   | sampling the stop bit; delivers the frame and returns to IDLE
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bclk,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [2:0]           state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pen_q, pen_d;
  logic                 podd_q, podd_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 deliver;
  logic                 ferr;

  // Two-flop synchronizer for the asynchronous serial line.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  // Frame FSM plus holding-register / handshake next-state logic.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    pen_d        = pen_q;
    podd_d       = podd_q;
    perr_d       = perr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    deliver      = 1'b0;
    ferr         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Config keeps tracking the inputs until a start is seen, then freezes.
        pen_d  = parity_en;
        podd_d = parity_odd;
        perr_d = 1'b0;
        if (bclk && !rx_s_q) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (bclk) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (!rx_s_q) begin
              state_d = S_DATA;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
      S_DATA: begin
        if (bclk) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_ONE;
            if (bit_q == BIT_LAST) begin
              state_d = pen_q ? S_PARITY : S_STOP;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
      S_PARITY: begin
        if (bclk) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            perr_d  = (^shift_q) ^ rx_s_q ^ podd_q;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
      S_STOP: begin
        if (bclk) begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            ferr    = ~rx_s_q;
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase

    // A delivery always wins over a read in the same cycle.
    if (deliver) begin
      data_d       = shift_q;
      frame_err_d  = ferr;
      parity_err_d = perr_q;
      valid_d      = 1'b1;
      if (rd_en) begin
        overrun_d = 1'b0;
      end else if (valid_q) begin
        overrun_d = 1'b1;
      end
    end else if (rd_en && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      pen_q        <= 1'b0;
      podd_q       <= 1'b0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      pen_q        <= pen_d;
      podd_q       <= podd_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_q;
  assign busy        = busy_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive stage of the UART transceiver, directly downstream of `baud_generator`. It consumes the 16x-oversampling tick `bclk` and the asynchronous serial line `rx`. It recovers 8N1 or 8E1/8O1 frames, sampling each bit at mid-bit. It presents each received byte in a one-entry holding register with valid/read handshake and per-frame error flags.

## Interface
Parameters:
- `OVERSAMPLE`, 16: `bclk` pulses per bit period; must be an even power of two ≥ 8.
- `DATA_BITS`, 8: data bits per frame, LSB first.

Ports:
- `clk`  in  1  system clock; the same clock that drives `baud_generator`.
- `reset`  in  1  synchronous, active-high reset.
- `bclk`  in  1  single-`clk`-cycle enable pulse at `OVERSAMPLE` × baud rate, from `baud_generator`.
- `rx`  in  1  asynchronous serial input; idles high.
- `parity_en`  in  1  1 = a parity bit follows the data bits.
- `parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `rd_en`  in  1  consumer read strobe; acknowledges the holding register.
- `rx_data`  out  `DATA_BITS`  received byte.
- `rx_valid`  out  1  holding register contains unread data.
- `frame_err`  out  1  stop bit sampled low for the frame in `rx_data`.
- `parity_err`  out  1  parity mismatch for the frame in `rx_data`.
- `overrun_err`  out  1  sticky flag: a frame was delivered while `rx_valid` = 1 without `rd_en`.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- Counters:
  - `tick_cnt`, log2(OVERSAMPLE) bits, advances only on `bclk`.
  - `bit_cnt`, log2(DATA_BITS) bits.
- IDLE:
  - On a `bclk` where `rx_s` = 0: go to START, `tick_cnt` ← 0.
  - Latch `parity_en`/`parity_odd` for the whole frame; later changes are ignored until the next IDLE.
- START:
  - On each `bclk`, `tick_cnt` increments.
  - On the `bclk` where `tick_cnt` = OVERSAMPLE/2−1, check `rx_s`:
    - 0: go to DATA, `tick_cnt` ← 0, `bit_cnt` ← 0.
    - 1: false start (glitch), go to IDLE; nothing is delivered.
- DATA:
  - On the `bclk` where `tick_cnt` = OVERSAMPLE−1 (one full bit after mid-start): shift `rx_s` into the MSB of the shift register (right-shift, LSB first on the line), `tick_cnt` ← 0.
  - After sampling bit DATA_BITS−1: go to PARITY if latched `parity_en`, else STOP.
- PARITY: sample at the same tick point. Compute `perr` = XOR(data bits, parity bit, latched `parity_odd`); mismatch → 1.
- STOP: sample at the same tick point; `ferr` = ~`rx_s`. Then deliver and return to IDLE in the same cycle. A new start can be detected from the next `bclk` onward.
- Delivery cycle:
  - `rx_data` ← shift register; `frame_err` ← `ferr`; `parity_err` ← `perr` (0 if parity disabled); `rx_valid` ← 1.
  - If `rx_valid` = 1 and `rd_en` = 0 in that cycle: `overrun_err` ← 1 and new data overwrites old.
- `rd_en` with `rx_valid` = 1 and no delivery: `rx_valid` ← 0 and `overrun_err` ← 0. `rx_data` and the error flags hold their values.
- `rd_en` and delivery in the same cycle: the new frame wins. `rx_valid` stays 1 and `overrun_err` is not set (it is cleared).
- `rd_en` with `rx_valid` = 0: no effect.
- `bclk` absent (held 0): the FSM freezes in its current state. No timeout.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun_err` = 0, `busy` = 0.
  - FSM = IDLE, both counters = 0, synchronizer = 1.
- Reset asserted mid-frame: the next cycle is IDLE with all of the above values. The partial frame is discarded.
- All outputs are registered and change on the `clk` edge after the qualifying `bclk`/`rd_en` cycle.
- Input latency: 2 `clk` cycles through the synchronizer, plus up to 1 `bclk` period of start-detect quantization.
- Output latency: `rx_valid` rises 1 `clk` after the `bclk` that samples the stop bit mid-bit. That is ≈ (1 + DATA_BITS + parity_en + 0.5) bit periods after the start edge.
- `busy` is 1 from the cycle after start detection until the delivery edge.

## Test plan
- Reset behaviour: hold `reset` = 1 for 3 cycles with `rx` toggling → every output is 0, `busy` = 0. Release reset → outputs are stable until a start bit arrives.
- Basic frame: `bclk` every 10 `clk`, parity off; send 0xA5 8N1 → `rx_valid` rises once, `rx_data` = 0xA5, all error flags 0. Pulse `rd_en` → `rx_valid` = 0 on the next cycle.
- Parity: `parity_en` = 1, `parity_odd` = 0.
  - Send 0x3C with parity bit 0 → `parity_err` = 0.
  - Resend with parity bit 1 → `parity_err` = 1, `rx_data` = 0x3C.
- Framing and glitch:
  - Send 0x55 with stop bit 0 → `frame_err` = 1.
  - A 3-`bclk`-long low glitch on idle `rx` → no delivery, `busy` returns to 0 at mid-start.
- Overrun and collision:
  - Send 0x11 then 0x22 with no `rd_en` → `rx_data` = 0x22, `overrun_err` = 1. `rd_en` clears both `rx_valid` and `overrun_err`.
  - `rd_en` exactly on the delivery cycle → `rx_valid` stays 1, `overrun_err` = 0.
- Reset mid-frame: assert `reset` during data bit 4 of 0xF0, then send 0x0F cleanly → only 0x0F is delivered, no error flags.
